// File: rtl/conv_pixel_streamer.sv
// rtl/conv_pixel_streamer.sv - frame buffer streamed as 3-row column beats for a 3x3 convolver
module conv_pixel_streamer #(
    parameter int ADDR_WIDTH         = 12,
    parameter int C_AXIS_TDATA_WIDTH = 32,
    parameter int PIXEL_NB           = 7,
    parameter int IMG_W              = 64,
    parameter int IMG_H              = 64
) (
    input  logic                              m00_axis_aclk,
    input  logic                              m00_axis_aresetn,
    input  logic                              i_wr_en,
    input  logic [ADDR_WIDTH-1:0]             i_wr_addr,
    input  logic [PIXEL_NB-1:0]               i_wr_data,
    input  logic                              i_start,
    output logic                              o_busy,
    output logic                              o_done,
    output logic [C_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic                              m00_axis_tvalid,
    input  logic                              m00_axis_tready,
    output logic                              m00_axis_tlast
);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] W_STEP    = ADDR_WIDTH'(IMG_W);
    localparam logic [ADDR_WIDTH-1:0] COL_LAST  = ADDR_WIDTH'(IMG_W - 1);
    localparam logic [ADDR_WIDTH-1:0] BAND_LAST = ADDR_WIDTH'(IMG_H - 3);

    state_t state_q, state_d;

    logic [PIXEL_NB-1:0] mem [2**ADDR_WIDTH];
    logic [PIXEL_NB-1:0] rd_data_q;
    logic                rd_valid_q, rd_last_q;

    logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
    logic [ADDR_WIDTH-1:0] koff_q, koff_d;
    logic [ADDR_WIDTH-1:0] col_q, col_d;
    logic [ADDR_WIDTH-1:0] band_q, band_d;
    logic [1:0]            k_q, k_d;

    logic [PIXEL_NB-1:0] head_q, head_d, tail_q, tail_d;
    logic                head_last_q, head_last_d, tail_last_q, tail_last_d;
    logic [1:0]          cnt_q, cnt_d;

    logic                  rd_en, rd_last, pop, can_issue;
    logic [2:0]            occ;
    logic [ADDR_WIDTH-1:0] rd_addr;

    assign pop     = (cnt_q != 2'd0) && m00_axis_tready;
    // Occupancy after this cycle's pop, counting the read already in flight.
    assign occ       = 3'(cnt_q) + 3'(rd_valid_q) - 3'(pop);
    assign can_issue = (occ <= 3'd1);
    assign rd_addr   = row_base_q + koff_q + col_q;
    assign rd_last   = (band_q == BAND_LAST) && (col_q == COL_LAST) && (k_q == 2'd2);

    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    rd_en   = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (can_issue) begin
                    rd_en = 1'b1;
                    if (rd_last) state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (!rd_valid_q && (cnt_d == 2'd0)) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        row_base_d = row_base_q;
        koff_d     = koff_q;
        col_d      = col_q;
        band_d     = band_q;
        k_d        = k_q;
        if (rd_en) begin
            if (rd_last) begin
                row_base_d = '0;
                koff_d     = '0;
                col_d      = '0;
                band_d     = '0;
                k_d        = '0;
            end else if (k_q == 2'd2) begin
                k_d    = '0;
                koff_d = '0;
                if (col_q == COL_LAST) begin
                    col_d      = '0;
                    band_d     = band_q + 1'b1;
                    row_base_d = row_base_q + W_STEP;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end else begin
                k_d    = k_q + 1'b1;
                koff_d = koff_q + W_STEP;
            end
        end
    end

    always_comb begin
        head_d      = head_q;
        head_last_d = head_last_q;
        tail_d      = tail_q;
        tail_last_d = tail_last_q;
        cnt_d       = cnt_q + 2'(rd_valid_q) - 2'(pop);
        if (pop && (cnt_q == 2'd2)) begin
            head_d      = tail_q;
            head_last_d = tail_last_q;
        end
        if (rd_valid_q) begin
            if ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop)) begin
                head_d      = rd_data_q;
                head_last_d = rd_last_q;
            end else begin
                tail_d      = rd_data_q;
                tail_last_d = rd_last_q;
            end
        end
    end

    // Frame buffer is deliberately outside the reset domain.
    always_ff @(posedge m00_axis_aclk) begin
        if (i_wr_en && (state_q == IDLE)) mem[i_wr_addr] <= i_wr_data;
        if (rd_en) rd_data_q <= mem[rd_addr];
    end

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            state_q     <= IDLE;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            row_base_q  <= '0;
            koff_q      <= '0;
            col_q       <= '0;
            band_q      <= '0;
            k_q         <= '0;
            head_q      <= '0;
            head_last_q <= 1'b0;
            tail_q      <= '0;
            tail_last_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            rd_valid_q  <= rd_en;
            rd_last_q   <= rd_en && rd_last;
            row_base_q  <= row_base_d;
            koff_q      <= koff_d;
            col_q       <= col_d;
            band_q      <= band_d;
            k_q         <= k_d;
            head_q      <= head_d;
            head_last_q <= head_last_d;
            tail_q      <= tail_d;
            tail_last_q <= tail_last_d;
            cnt_q       <= cnt_d;
        end
    end

    assign o_busy          = (state_q == STREAM) || (state_q == FLUSH);
    assign o_done          = (state_q == DONE);
    assign m00_axis_tvalid = (cnt_q != 2'd0);
    assign m00_axis_tlast  = head_last_q && (cnt_q != 2'd0);
    assign m00_axis_tdata  = {{(C_AXIS_TDATA_WIDTH-PIXEL_NB){1'b0}}, head_q};
    assign m00_axis_tstrb  = {(C_AXIS_TDATA_WIDTH/8){1'b1}};

endmodule

// File: tb/tb_conv_pixel_streamer.sv
// tb/tb_conv_pixel_streamer.sv - randomized self-checking bench for conv_pixel_streamer
module tb_conv_pixel_streamer;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int PN = 7;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int NBEATS = (H - 2) * 3 * W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [PN-1:0]   wr_data;
    logic            start;
    logic            busy, done;
    logic [DW-1:0]   tdata;
    logic [DW/8-1:0] tstrb;
    logic            tvalid, tlast;
    logic            tready = 1'b0;

    conv_pixel_streamer #(
        .ADDR_WIDTH(AW), .C_AXIS_TDATA_WIDTH(DW), .PIXEL_NB(PN), .IMG_W(W), .IMG_H(H)
    ) dut (
        .m00_axis_aclk(clk),
        .m00_axis_aresetn(rst_n),
        .i_wr_en(wr_en),
        .i_wr_addr(wr_addr),
        .i_wr_data(wr_data),
        .i_start(start),
        .o_busy(busy),
        .o_done(done),
        .m00_axis_tdata(tdata),
        .m00_axis_tstrb(tstrb),
        .m00_axis_tvalid(tvalid),
        .m00_axis_tready(tready),
        .m00_axis_tlast(tlast)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [PN-1:0] model [1<<AW];
    logic [DW-1:0] exp_q[$];

    function automatic void build_expected();
        exp_q.delete();
        for (int r = 0; r <= H - 3; r++)
            for (int c = 0; c < W; c++)
                for (int k = 0; k < 3; k++)
                    exp_q.push_back(DW'(model[(r + k) * W + c]));
    endfunction

    int            cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rdy_mode = 1;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       tready = 1'b0;
            1:       tready = 1'b1;
            default: tready = 1'($urandom_range(0, 1));
        endcase
    end

    bit            mon_en = 1'b0;
    logic [DW-1:0] cap_d[$];
    bit            cap_l[$];
    int            first_hs, last_hs, done_cyc, done_cnt;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_stall) begin
                check("stall_valid", 32'(tvalid), 32'd1);
                check("stall_data", tdata, prev_data);
                check("stall_last", 32'(tlast), 32'(prev_last));
            end
            if (tvalid && tready) begin
                if (cap_d.size() == 0) first_hs = cyc;
                cap_d.push_back(tdata);
                cap_l.push_back(tlast);
                if (tlast) last_hs = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_last  = tlast;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic wr(input int a, input int d, input bit upd);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = PN'(d);
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (upd) model[a] = PN'(d);
    endtask

    task automatic clear_capture();
        cap_d.delete(); cap_l.delete();
        done_cnt = 0; done_cyc = -1; last_hs = -1; first_hs = -1;
    endtask

    task automatic run_frame(input int mode, input bit disturb, input int stall, input string tag);
        int n;
        build_expected();
        clear_capture();
        rdy_mode = (stall > 0) ? 0 : mode;
        @(posedge clk); #1;
        start = 1'b1; mon_en = 1'b1;
        @(negedge clk);
        check({tag, "_lat0_valid"}, 32'(tvalid), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check({tag, "_lat1_valid"}, 32'(tvalid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        @(negedge clk);
        check({tag, "_lat2_valid"}, 32'(tvalid), 32'd1);
        if (disturb) begin
            @(posedge clk); #1;
            start = 1'b1; wr_en = 1'b1; wr_addr = AW'(5); wr_data = PN'(7'h55);
            @(posedge clk); #1;
            start = 1'b0; wr_en = 1'b0;
        end
        if (stall > 0) begin
            repeat (stall - 2) begin
                @(negedge clk);
                check({tag, "_hold_valid"}, 32'(tvalid), 32'd1);
                check({tag, "_hold_data"}, tdata, 32'h0);
                check({tag, "_hold_busy"}, 32'(busy), 32'd1);
            end
            rdy_mode = mode;
        end
        n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        check({tag, "_beats"}, 32'(cap_d.size()), 32'(NBEATS));
        for (int i = 0; i < NBEATS && i < cap_d.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), cap_d[i], exp_q[i]);
            check($sformatf("%s_last%0d", tag, i), 32'(cap_l[i]), 32'(i == NBEATS - 1));
        end
        check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        check({tag, "_done_timing"}, 32'(done_cyc), 32'(last_hs + 1));
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        if (mode == 1 && stall == 0)
            check({tag, "_throughput"}, 32'(last_hs - first_hs), 32'(NBEATS - 1));
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (3) @(negedge clk);
        check("rst_tvalid", 32'(tvalid), 32'd0);
        check("rst_tlast", 32'(tlast), 32'd0);
        check("rst_tdata", tdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;

        for (int a = 0; a < W * H; a++) wr(a, a, 1'b1);
        run_frame(1, 1'b0, 0, "ramp");
        run_frame(2, 1'b0, 0, "ramp_rnd");

        wr(0, 'h7F, 1'b1);
        run_frame(1, 1'b0, 0, "p7f");
        check("p7f_first", cap_d[0], 32'h0000007F);
        check("p7f_tstrb", 32'(tstrb), 32'hF);

        run_frame(1, 1'b1, 0, "ignore");
        run_frame(2, 1'b0, 0, "after_ignore");

        build_expected();
        clear_capture();
        rdy_mode = 1;
        @(posedge clk); #1;
        start = 1'b1; mon_en = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (cap_d.size() < 10 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("mid_reached10", 32'(cap_d.size() >= 10), 32'd1);
        for (int i = 0; i < 10 && i < cap_d.size(); i++)
            check($sformatf("mid_data%0d", i), cap_d[i], exp_q[i]);
        @(posedge clk); #2;
        rst_n = 1'b0; mon_en = 1'b0;
        #1;
        check("mid_rst_tvalid", 32'(tvalid), 32'd0);
        check("mid_rst_tlast", 32'(tlast), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("mid_rst_hold_tvalid", 32'(tvalid), 32'd0);
        end
        rst_n = 1'b1;
        run_frame(1, 1'b0, 0, "post_rst");

        wr(0, 0, 1'b1);
        run_frame(2, 1'b0, 50, "stall50");

        for (int f = 0; f < 4; f++) begin
            for (int a = 0; a < W * H; a++) wr(a, int'($urandom_range(0, 127)), 1'b1);
            run_frame((f % 2 == 0) ? 2 : 1, 1'b0, 0, $sformatf("rand%0d", f));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/conv_pixel_streamer.md
CONV_PIXEL_STREAMER -- requirements
Module: conv_pixel_streamer

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, SHALL set the frame buffer depth to 2^ADDR_WIDTH pixels.
REQ-002 Parameter C_AXIS_TDATA_WIDTH, default 32, SHALL set the stream data width.
REQ-003 Parameter PIXEL_NB, default 7, SHALL set the stored pixel width.
REQ-004 Parameters IMG_W and IMG_H, default 64 each, SHALL set the image size; IMG_W, IMG_H >= 3 and IMG_W*IMG_H <= 2^ADDR_WIDTH.
REQ-005 Clock and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-006 Ports SHALL be as follows.
- m00_axis_aclk  in  1  sole clock
- m00_axis_aresetn  in  1  asynchronous active-low reset
- i_wr_en  in  1  frame buffer write strobe
- i_wr_addr  in  ADDR_WIDTH  write address, row-major (row*IMG_W+col)
- i_wr_data  in  PIXEL_NB  pixel to store
- i_start  in  1  one-cycle frame start request
- o_busy  out  1  frame in progress
- o_done  out  1  one-cycle pulse after the last beat is accepted
- m00_axis_tdata  out  C_AXIS_TDATA_WIDTH  pixel, zero-extended
- m00_axis_tstrb  out  C_AXIS_TDATA_WIDTH/8  constant all ones
- m00_axis_tvalid  out  1  beat valid
- m00_axis_tready  in  1  downstream ready
- m00_axis_tlast  out  1  last beat of frame

Function
REQ-007 The block SHALL hold a 2^ADDR_WIDTH x PIXEL_NB frame buffer with synchronous 1-cycle read latency; writes SHALL occur only in IDLE, and i_wr_en in any other state SHALL be ignored.
REQ-008 The FSM SHALL have states IDLE, STREAM, FLUSH and DONE; IDLE->STREAM on i_start, STREAM->FLUSH after the final read is issued, FLUSH->DONE when the output buffer is empty, DONE->IDLE after 1 cycle.
REQ-009 o_busy SHALL be 1 in STREAM and FLUSH; o_done SHALL be 1 only in DONE; i_start outside IDLE SHALL be ignored.
REQ-010 Beat order SHALL feed a 3x3 column-shift convolver: for band r = 0..IMG_H-3, for column c = 0..IMG_W-1, for k = 0..2, emit pixel at address (r+k)*IMG_W + c.
REQ-011 The frame SHALL total (IMG_H-2)*3*IMG_W beats; tlast SHALL be 1 only on the final beat (band IMG_H-3, column IMG_W-1, k=2).
REQ-012 Address generation SHALL use a running row-base register (add IMG_W per band); no multiplier.
REQ-013 Reads SHALL feed a 2-entry output skid buffer; a read SHALL be issued only when the buffer can accept its data, counting in-flight reads.
REQ-014 AXI-Stream rules: tdata and tlast SHALL stay stable while tvalid=1 and tready=0; tvalid SHALL not drop without a handshake; a beat SHALL transfer on tvalid & tready.
REQ-015 With tready held at 1, throughput SHALL be 1 beat per cycle; the first tvalid SHALL assert 2 cycles after the i_start cycle.
REQ-016 tdata SHALL equal {zeros, pixel[PIXEL_NB-1:0]}.

Reset
REQ-017 During reset: FSM=IDLE, counters=0, skid buffer empty, tvalid=0, tlast=0, tdata=0, o_busy=0, o_done=0; frame buffer contents SHALL be unaffected.
REQ-018 Reset mid-frame SHALL abort immediately with no further beats; a subsequent i_start SHALL restart from band 0, column 0.

Verification
REQ-019 IMG_W=IMG_H=4, pixel[a]=a, tready=1, i_start -> 24 beats: 0,4,8,1,5,9,2,6,10,3,7,11,4,8,12,...,15; tlast only on beat 24; o_done 1 cycle later.
REQ-020 Same frame, tready toggled pseudo-randomly -> identical 24-value sequence; no tdata/tlast change while stalled.
REQ-021 Write 7'h7F at address 0, stream -> first beat tdata=32'h0000007F, tstrb=4'hF.
REQ-022 i_start and i_wr_en pulsed during STREAM -> ignored; sequence and buffer contents unchanged.
REQ-023 Reset asserted after beat 10 -> tvalid=0 at once; a new i_start yields the full 24 beats from pixel 0.
REQ-024 tready=0 for 50 cycles after i_start -> tvalid=1 and tdata=0 held throughout; o_busy=1.
